store_check_monitor: RTL
========================

// Module: store_check_monitor
// PURPOSE
//  Synthesizable pass/fail monitor for CPU data-memory stores; sits beside the CPU core on
//  memwrite/dataaddr/writedata. Replaces ad-hoc bench checks, so FPGA and simulation runs report
//  identical verdicts. Adds a scratch address window, a completion store, a cycle timeout,
//  store counting and capture of the first offending store.
// PARAMETERS
//  ADDR_W       32     width of dataaddr
//  DATA_W       32     width of writedata
//  PASS_ADDR    84     store address that signals completion
//  PASS_DATA    7      value required at PASS_ADDR for PASS
//  SCRATCH_LO   80     lowest permitted non-completion store address (inclusive)
//  SCRATCH_HI   80     highest permitted non-completion store address (inclusive)
//  TIMEOUT_CYC  4096   RUN cycles before TIMEOUT verdict; 0 disables timeout
//  CNT_W        16     width of store_cnt (saturating)
//  LOG_DEPTH    8      store-log entries, power of 2 (STORE_LOG_EN only)
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       asynchronous, active-low reset
//  memwrite     in   1       CPU store strobe, one store per asserted cycle
//  dataaddr     in   ADDR_W  store address
//  writedata    in   DATA_W  store data
//  done         out  1       verdict reached (sticky)
//  pass         out  1       verdict = PASS (sticky)
//  fail_code    out  2       0 none, 1 bad data at PASS_ADDR, 2 address outside window, 3 timeout
//  fail_addr    out  ADDR_W  address of first offending store (0 for timeout)
//  fail_data    out  DATA_W  data of first offending store (0 for timeout)
//  store_cnt    out  CNT_W   stores accepted in RUN, saturates at all-ones
//  log_idx      in   log2(LOG_DEPTH)  log read index, 0 = newest (STORE_LOG_EN only)
//  log_addr     out  ADDR_W  logged address at log_idx (STORE_LOG_EN only)
//  log_data     out  DATA_W  logged data at log_idx (STORE_LOG_EN only)
// BEHAVIOUR
//  - Reset (reset=0, asynchronous): state=RUN, every output 0, timer 0, log pointer 0.
//  - FSM: RUN -> PASS | FAIL | TIMEOUT. All three are terminal until reset; inputs are ignored.
//  - Inputs are sampled at posedge clk. Verdict outputs update at the same edge; 1-cycle latency.
//  - RUN + memwrite: addr==PASS_ADDR && data==PASS_DATA -> PASS, pass=1.
//    addr==PASS_ADDR with other data -> FAIL, code 1.
//    addr outside [SCRATCH_LO,SCRATCH_HI] -> FAIL, code 2. Otherwise stay in RUN.
//  - PASS_ADDR is checked before the window, so PASS_ADDR inside the window still completes.
//  - On entry to FAIL, fail_addr/fail_data capture the offending store; they stay frozen afterwards.
//  - done=1 in PASS/FAIL/TIMEOUT. pass=1 only in PASS.
//  - store_cnt increments on every memwrite sampled in RUN, including the verdict store.
//  - Timer counts RUN cycles. When the timer reaches TIMEOUT_CYC-1 with no store verdict in
//    that cycle -> TIMEOUT, code 3. A store verdict in the same cycle takes priority.
//  - memwrite with X/Z on any input is treated as an out-of-window store (code 2).
//  - Reset asserted mid-run aborts immediately; counters and captures clear.
// CONFIGURATION
//  STORE_LOG_EN defined:
//   - circular log of the last LOG_DEPTH stores accepted in RUN; write pointer wraps.
//   - log_addr/log_data are combinational reads at (wptr-1-log_idx).
//   - entries never written read 0; the log freezes once done=1.
//  STORE_LOG_EN undefined:
//   - log_idx/log_addr/log_data ports are absent and no log storage is built.
//   - all other behaviour is identical.
// TESTING
//  1 stores (80,1),(80,2),(84,7) -> PASS one edge after 3rd store; store_cnt=3, fail_code=0
//  2 store (84,5) -> FAIL, fail_code=1, fail_addr=84, fail_data=5; later (84,7) ignored
//  3 store (96,3) -> FAIL, fail_code=2, fail_addr=96, fail_data=3, pass=0
//  4 TIMEOUT_CYC=16, no stores -> done=1 and fail_code=3 after exactly 16 edges; a (84,7)
//    store on edge 16 gives PASS instead
//  5 reset=0 for 1ns mid-RUN after 2 stores -> outputs clear asynchronously; run restarts
//  6 STORE_LOG_EN, LOG_DEPTH=4, 6 in-window stores then (84,7) -> log_idx 0..3 returns the
//    last 4 stores, newest first

Source files
------------

// File: rtl/store_check_monitor.sv
// Pass/fail monitor for CPU data-memory stores: completion store, scratch window, timeout, first-fault capture.
// Optional store log is built when STORE_LOG_EN is defined.
`timescale 1ns/1ps
module store_check_monitor #(
   parameter int                ADDR_W      = 32,
   parameter int                DATA_W      = 32,
   parameter logic [ADDR_W-1:0] PASS_ADDR   = 'd84,
   parameter logic [DATA_W-1:0] PASS_DATA   = 'd7,
   parameter logic [ADDR_W-1:0] SCRATCH_LO  = 'd80,
   parameter logic [ADDR_W-1:0] SCRATCH_HI  = 'd80,
   parameter int                TIMEOUT_CYC = 4096,
   parameter int                CNT_W       = 16,
   parameter int                LOG_DEPTH   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              memwrite,
   input  logic [ADDR_W-1:0] dataaddr,
   input  logic [DATA_W-1:0] writedata,
   output logic              done,
   output logic              pass,
   output logic [1:0]        fail_code,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [DATA_W-1:0] fail_data,
   output logic [CNT_W-1:0]  store_cnt
`ifdef STORE_LOG_EN
   ,
   input  logic [$clog2(LOG_DEPTH)-1:0] log_idx,
   output logic [ADDR_W-1:0]            log_addr,
   output logic [DATA_W-1:0]            log_data
`endif
);

   typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_t;

   localparam int TW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int TLIM = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

   state_t            state, state_nx;
   logic [TW-1:0]     timer;
   logic [1:0]        code_nx;
   logic [ADDR_W-1:0] addr_nx;
   logic [DATA_W-1:0] data_nx;
   logic              accept;
   logic              in_unknown;
   logic              out_window;
   logic              timeout_hit;

   // Unknown bits only exist in simulation; in hardware this folds to 0.
   assign in_unknown  = ((^{memwrite, dataaddr, writedata}) === 1'bx);
   assign out_window  = (dataaddr < SCRATCH_LO) || (dataaddr > SCRATCH_HI);
   assign timeout_hit = (TIMEOUT_CYC != 0) && (timer == TW'(TLIM));

   always_comb begin
      state_nx = state;
      code_nx  = fail_code;
      addr_nx  = fail_addr;
      data_nx  = fail_data;
      accept   = 1'b0;
      if (state == S_RUN) begin
         if (memwrite !== 1'b0) begin
            accept = 1'b1;
            if (in_unknown || (dataaddr != PASS_ADDR && out_window)) begin
               state_nx = S_FAIL;
               code_nx  = 2'd2;
               addr_nx  = dataaddr;
               data_nx  = writedata;
            end else if (dataaddr == PASS_ADDR) begin
               if (writedata == PASS_DATA) begin
                  state_nx = S_PASS;
               end else begin
                  state_nx = S_FAIL;
                  code_nx  = 2'd1;
                  addr_nx  = dataaddr;
                  data_nx  = writedata;
               end
            end
         end
         // A store verdict in the final cycle wins over the timeout.
         if (state_nx == S_RUN && timeout_hit) begin
            state_nx = S_TIMEOUT;
            code_nx  = 2'd3;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_RUN;
         timer     <= '0;
         fail_code <= 2'd0;
         fail_addr <= '0;
         fail_data <= '0;
         store_cnt <= '0;
      end else begin
         state     <= state_nx;
         fail_code <= code_nx;
         fail_addr <= addr_nx;
         fail_data <= data_nx;
         if (state == S_RUN)
            timer <= timer + TW'(1);
         if (accept && store_cnt != {CNT_W{1'b1}})
            store_cnt <= store_cnt + CNT_W'(1);
      end
   end

   assign done = (state != S_RUN);
   assign pass = (state == S_PASS);

`ifdef STORE_LOG_EN
   localparam int LW = $clog2(LOG_DEPTH);

   logic [ADDR_W-1:0] log_a [LOG_DEPTH];
   logic [DATA_W-1:0] log_d [LOG_DEPTH];
   logic [LW-1:0]     wptr;
   logic [LW-1:0]     rptr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr <= '0;
         for (int i = 0; i < LOG_DEPTH; i++) begin
            log_a[i] <= '0;
            log_d[i] <= '0;
         end
      end else if (accept) begin
         log_a[wptr] <= dataaddr;
         log_d[wptr] <= writedata;
         wptr        <= wptr + LW'(1);
      end
   end

   // Newest entry sits just behind the write pointer; depth is a power of 2 so the pointer wraps.
   assign rptr     = wptr - LW'(1) - log_idx;
   assign log_addr = log_a[rptr];
   assign log_data = log_d[rptr];
`endif

endmodule
